// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - mode encodings shared by the mode sequencer and the time/date counters
package clock_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RUN       = 3'd0,
    SET_SEC   = 3'd1,
    SET_MIN   = 3'd2,
    SET_HOUR  = 3'd3,
    SHOW_DATE = 3'd4,
    SET_DAY   = 3'd5,
    SET_MONTH = 3'd6,
    SET_YEAR  = 3'd7
  } mode_e;

  // Modes in which SET edits a counter field.
  function automatic logic is_edit(input logic [STATE_W-1:0] s);
    return (s != RUN) && (s != SHOW_DATE);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - push-button synchroniser, press detector and saturating hold counter
module btn_sync_edge #(
  parameter int CNT_W = 5
) (
  input  logic             clk_1Hz,
  input  logic             rst_n,
  input  logic             btn_n_i,
  input  logic             clr_i,
  output logic             press_o,
  output logic             held_o,
  output logic [CNT_W-1:0] hold_cnt_o
);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (clr_i || sync2_q)
      hold_cnt_d = '0;
    else if (hold_cnt_q != '1)
      hold_cnt_d = hold_cnt_q + 1'b1;
  end

  // Flops reset to the released (high) level so reset never fakes a press.
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      hold_cnt_q <= '0;
    end else begin
      sync1_q    <= btn_n_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign press_o    = prev_q & ~sync2_q;
  assign held_o     = ~sync2_q;
  assign hold_cnt_o = hold_cnt_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - front-panel MODE/SET sequencer with auto-repeat, edit timeout and blink
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int state_num    = 8,
  parameter int TIMEOUT      = 30,
  parameter int REPEAT_DELAY = 2,
  parameter int CNT_W        = 5
) (
  input  logic               clk_1Hz,
  input  logic               rst_n,
  input  logic               mode_btn_n,
  input  logic               set_btn_n,
  output logic [STATE_W-1:0] state,
  output logic               set_button,
  output logic               blink,
  output logic               edit_active
);

  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   REPEAT_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [STATE_W-1:0] LAST_MODE = STATE_W'(state_num - 1);

  mode_e            state_q, state_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             set_button_q, set_button_d;
  logic             blink_q, blink_d;
  logic             edit_q, edit_d;
  logic             rpt_hit, state_chg;

  logic             mode_press, mode_held;
  logic [CNT_W-1:0] mode_hold_cnt;
  logic             set_press, set_held;
  logic [CNT_W-1:0] set_hold_cnt;
  logic             unused_mode;

  btn_sync_edge #(.CNT_W(CNT_W)) u_mode_btn (
    .clk_1Hz    (clk_1Hz),
    .rst_n      (rst_n),
    .btn_n_i    (mode_btn_n),
    .clr_i      (state_chg),
    .press_o    (mode_press),
    .held_o     (mode_held),
    .hold_cnt_o (mode_hold_cnt)
  );

  btn_sync_edge #(.CNT_W(CNT_W)) u_set_btn (
    .clk_1Hz    (clk_1Hz),
    .rst_n      (rst_n),
    .btn_n_i    (set_btn_n),
    .clr_i      (state_chg),
    .press_o    (set_press),
    .held_o     (set_held),
    .hold_cnt_o (set_hold_cnt)
  );

  assign unused_mode = ^{mode_held, mode_hold_cnt};

  // MODE beats SET; a fresh SET press beats the timeout; repeat does not.
  always_comb begin
    state_d      = state_q;
    idle_d       = idle_q;
    set_button_d = 1'b1;
    rpt_hit      = set_held && (set_hold_cnt >= REPEAT_C);
    if (mode_press)
      state_d = (state_q == LAST_MODE) ? RUN : mode_e'(state_q + 1'b1);
    else if (!set_press && (idle_q == TIMEOUT_C))
      state_d = RUN;
    else if (is_edit(state_q) && (set_press || rpt_hit))
      set_button_d = 1'b0;

    if ((state_q == RUN) || mode_press || set_press)
      idle_d = '0;
    else if (idle_q != TIMEOUT_C)
      idle_d = idle_q + 1'b1;

    blink_d = is_edit(state_d) ? ~blink_q : 1'b0;
    edit_d  = is_edit(state_d);
  end

  assign state_chg = (state_d != state_q);

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      idle_q       <= '0;
      set_button_q <= 1'b1;
      blink_q      <= 1'b0;
      edit_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      set_button_q <= set_button_d;
      blink_q      <= blink_d;
      edit_q       <= edit_d;
    end
  end

  assign state       = state_q;
  assign set_button  = set_button_q;
  assign blink       = blink_q;
  assign edit_active = edit_q;

endmodule
